alu_iter_exec: RTL and testbench

//  EX-stage execution unit consuming the 3-bit ALU control code from the ALU control decoder.

---
 rtl/alu_iter_exec_if.sv | 57 +++++
 rtl/alu_iter_exec.sv | 172 +++++++++++++++++
 tb/tb_alu_iter_exec.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_exec_if.sv
// ---------------------------------------------------------------------------
// alu_iter_exec_if
// Request/result bundle between the EX-stage issue logic and alu_iter_exec.
//
//   valid_i    requester -> unit   operation request valid
//   flush_i    requester -> unit   abort in-flight op / drop pending result
//   ALUCtrl_i  requester -> unit   3-bit operation code from ALU control
//   data1_i    requester -> unit   operand A (rs)
//   data2_i    requester -> unit   operand B (rt or sign-extended immediate)
//   ready_o    unit -> requester   unit can accept a request this cycle
//   busy_o     unit -> requester   inverse of ready_o, drives pipeline stall
//   valid_o    unit -> requester   one-cycle pulse, new result on data_o
//   data_o     unit -> requester   registered result
//   zero_o     unit -> requester   data_o == 0, used for branch compare
//
// The master modport is the requester side; the slave modport is the unit.
// ---------------------------------------------------------------------------
interface alu_iter_exec_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             flush_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    modport master (
        output valid_i,
        output flush_i,
        output ALUCtrl_i,
        output data1_i,
        output data2_i,
        input  ready_o,
        input  busy_o,
        input  valid_o,
        input  data_o,
        input  zero_o
    );

    modport slave (
        input  valid_i,
        input  flush_i,
        input  ALUCtrl_i,
        input  data1_i,
        input  data2_i,
        output ready_o,
        output busy_o,
        output valid_o,
        output data_o,
        output zero_o
    );
endinterface

// File: rtl/alu_iter_exec.sv
// ---------------------------------------------------------------------------
// alu_iter_exec
// EX-stage execution unit. add/sub/and/or (and the reserved codes, which
// return zero) complete in a single cycle; multiply runs as an iterative
// shift-add retiring MUL_STEP multiplier bits per cycle, so it occupies the
// unit for WIDTH/MUL_STEP cycles. While a multiply is in flight busy_o is high
// so the hazard unit can stall IF/ID/EX. The result is registered and feeds
// the EX/MEM pipeline register.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous, active-high reset
//   bus     alu_iter_exec_if.slave (request, operands, result, handshake)
//
// Parameters:
//   WIDTH     operand/result width
//   MUL_STEP  multiplier bits retired per cycle; must divide WIDTH
// ---------------------------------------------------------------------------
module alu_iter_exec #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_iter_exec_if.slave bus
);

    localparam int N     = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(N) + 1;

    // Step index whose completion finishes the multiply
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [WIDTH-1:0] single_result;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_step;

    // ready/busy come straight from the state so the stall is glitch-free
    // and independent of the incoming request.
    assign bus.ready_o = (state_q == IDLE);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.zero_o  = (data_q == '0);

    // A flush on the same edge suppresses the accept.
    assign accept = bus.valid_i & (state_q == IDLE) & ~bus.flush_i;

    // Single-cycle operations; reserved codes (and mul, which never uses
    // this path) give zero.
    always_comb begin
        single_result = '0;
        case (bus.ALUCtrl_i)
            OP_ADD:  single_result = bus.data1_i + bus.data2_i;
            OP_SUB:  single_result = bus.data1_i - bus.data2_i;
            OP_AND:  single_result = bus.data1_i & bus.data2_i;
            OP_OR:   single_result = bus.data1_i | bus.data2_i;
            default: single_result = '0;
        endcase
    end

    // multiplicand * multiplier[MUL_STEP-1:0], built as a sum of shifted
    // multiplicands so MUL_STEP > 1 needs no hard multiplier. Truncation to
    // WIDTH bits is intended: only the low half of the product is returned.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        acc_step = acc_q + partial;
    end

    // Next-state and datapath update. valid_d defaults low so valid_o is a
    // single-cycle pulse; data_d defaults to hold so the result survives
    // idle cycles and flushes.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.ALUCtrl_i == OP_MUL) begin
                            mcand_d  = bus.data1_i;
                            mplier_d = bus.data2_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = MUL;
                        end else begin
                            data_d  = single_result;
                            valid_d = 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        data_d  = acc_step;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_alu_iter_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_iter_exec
// Directed bench for alu_iter_exec at WIDTH=32, MUL_STEP=1. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_alu_iter_exec;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   failures;

    alu_iter_exec_if #(.WIDTH(32)) bus ();

    alu_iter_exec #(
        .WIDTH    (32),
        .MUL_STEP (1)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] ctrl,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = valid;
        bus.ALUCtrl_i = ctrl;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Waits out a multiply that was accepted on the previous edge, counting
    // the cycles ready_o stays low and noting any premature valid_o.
    task automatic waitMulDone(output int low_cycles, output logic saw_early);
        low_cycles = 0;
        saw_early  = 1'b0;
        while (bus.ready_o !== 1'b1 && low_cycles < 40) begin
            low_cycles++;
            if (bus.valid_o !== 1'b0) saw_early = 1'b1;
            tick();
        end
    endtask

    initial begin
        int   low_cycles;
        logic saw_early;
        logic saw_valid;

        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        bus.flush_i = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);

        // Reset values
        tick();
        checkOutput("rst_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("rst_busy",  32'(bus.busy_o),  32'd0);
        checkOutput("rst_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("rst_data",  bus.data_o,       32'd0);
        checkOutput("rst_zero",  32'(bus.zero_o),  32'd1);
        rst_i = 1'b0;
        tick();

        // add 5+7
        applyStimulus(1'b1, 3'b000, 32'd5, 32'd7);
        tick();
        checkOutput("add_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("add_data",  bus.data_o,       32'd12);
        checkOutput("add_zero",  32'(bus.zero_o),  32'd0);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        checkOutput("add_valid_drop", 32'(bus.valid_o), 32'd0);
        checkOutput("add_data_hold",  bus.data_o,       32'd12);

        // sub 3-3 then or back-to-back
        applyStimulus(1'b1, 3'b001, 32'd3, 32'd3);
        tick();
        checkOutput("sub_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("sub_data",  bus.data_o,       32'd0);
        checkOutput("sub_zero",  32'(bus.zero_o),  32'd1);
        applyStimulus(1'b1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
        tick();
        checkOutput("or_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("or_data",  bus.data_o,       32'h0000_00FF);
        checkOutput("or_zero",  32'(bus.zero_o),  32'd0);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        checkOutput("or_valid_drop", 32'(bus.valid_o), 32'd0);

        // and 0xF0F0 & 0x0FF0
        applyStimulus(1'b1, 3'b010, 32'h0000_F0F0, 32'h0000_0FF0);
        tick();
        checkOutput("and_data", bus.data_o, 32'h0000_00F0);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        tick();

        // mul 6*7
        applyStimulus(1'b1, 3'b100, 32'd6, 32'd7);
        tick();
        checkOutput("mul_busy",  32'(bus.busy_o),  32'd1);
        checkOutput("mul_valid_low", 32'(bus.valid_o), 32'd0);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        waitMulDone(low_cycles, saw_early);
        checkOutput("mul_low_cycles", 32'(low_cycles), 32'd32);
        checkOutput("mul_no_early_valid", 32'(saw_early), 32'd0);
        checkOutput("mul_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("mul_data",  bus.data_o,       32'd42);
        tick();
        checkOutput("mul_valid_drop", 32'(bus.valid_o), 32'd0);

        // 0xFFFFFFFF * 2 wraps to the low word
        applyStimulus(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd2);
        tick();
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        waitMulDone(low_cycles, saw_early);
        checkOutput("mulwrap_low_cycles", 32'(low_cycles), 32'd32);
        checkOutput("mulwrap_data", bus.data_o, 32'hFFFF_FFFE);
        tick();

        // add held on valid_i during a multiply: accepted only once free
        applyStimulus(1'b1, 3'b100, 32'd3, 32'd5);
        tick();
        applyStimulus(1'b1, 3'b000, 32'd1, 32'd2);
        waitMulDone(low_cycles, saw_early);
        checkOutput("held_no_early_valid", 32'(saw_early), 32'd0);
        checkOutput("held_mul_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("held_mul_data",  bus.data_o,       32'd15);
        tick();
        checkOutput("held_add_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("held_add_data",  bus.data_o,       32'd3);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        checkOutput("held_valid_drop", 32'(bus.valid_o), 32'd0);

        // flush at cycle 10 of a multiply
        applyStimulus(1'b1, 3'b100, 32'd9, 32'd9);
        tick();
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("flush_pre_busy", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("flush_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("flush_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("flush_data",  bus.data_o,       32'd3);
        saw_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (bus.valid_o !== 1'b0) saw_valid = 1'b1;
        end
        checkOutput("flush_no_late_valid", 32'(saw_valid), 32'd0);
        applyStimulus(1'b1, 3'b000, 32'd10, 32'd20);
        tick();
        checkOutput("flush_then_add_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("flush_then_add_data",  bus.data_o,       32'd30);

        // flush blocks an accept on the same edge
        applyStimulus(1'b1, 3'b000, 32'd1, 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        checkOutput("flush_block_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("flush_block_data",  bus.data_o,       32'd30);
        tick();

        // reset pulsed between edges mid-multiply
        applyStimulus(1'b1, 3'b100, 32'd6, 32'd7);
        tick();
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("midrst_busy",  32'(bus.busy_o),  32'd0);
        checkOutput("midrst_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("midrst_data",  bus.data_o,       32'd0);
        checkOutput("midrst_zero",  32'(bus.zero_o),  32'd1);
        tick();
        rst_i = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (bus.valid_o !== 1'b0) saw_valid = 1'b1;
        end
        checkOutput("midrst_no_valid", 32'(saw_valid), 32'd0);

        // reserved codes 101 and 111 return zero with a valid pulse
        applyStimulus(1'b1, 3'b000, 32'd1, 32'd1);
        tick();
        checkOutput("pre_rsv_data", bus.data_o, 32'd2);
        applyStimulus(1'b1, 3'b101, 32'd5, 32'd5);
        tick();
        checkOutput("rsv101_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("rsv101_data",  bus.data_o,       32'd0);
        checkOutput("rsv101_zero",  32'(bus.zero_o),  32'd1);
        applyStimulus(1'b1, 3'b111, 32'hDEAD_BEEF, 32'h1234_5678);
        tick();
        checkOutput("rsv111_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("rsv111_data",  bus.data_o,       32'd0);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        checkOutput("rsv_valid_drop", 32'(bus.valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
